pipeline_hazard_sequencer: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards and taken-branch flushes.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Drives the noop input of the main decoder, plus PC, IF/ID and back-end hold enables.
- Tracks stall/flush statistics and flags a memory timeout.

---
 rtl/pipeline_hazard_sequencer_pkg.sv | 15 +
 rtl/pipeline_hazard_sequencer_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_sequencer.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: sequencer state
// encoding, default register-index width and the hard-wired zero register.
package pipeline_hazard_sequencer_pkg;

   localparam int DEFAULT_REG_ADDR_W = 5;
   localparam int X0_IDX             = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERR      = 2'd3
   } state_e;

endpackage

// File: rtl/pipeline_hazard_sequencer_load_use_detect.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID reads, so ID must wait one cycle for the loaded value.
module hazard_load_use_detect
   import pipeline_hazard_sequencer_pkg::*;
#(
   parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_uses_rs2,
   output logic                  load_use
);

   logic rd_is_x0;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is never written, so a load targeting it creates no dependency.
   assign rd_is_x0 = (idex_rd == REG_ADDR_W'(X0_IDX));
   assign rs1_hit  = (idex_rd == ifid_rs1);
   assign rs2_hit  = ifid_uses_rs2 && (idex_rd == ifid_rs2);
   assign load_use = idex_memread && !rd_is_x0 && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline: hazard response is
// combinational from state and inputs; statistics and the timeout flag are registered.
module pipeline_hazard_sequencer
   import pipeline_hazard_sequencer_pkg::*;
#(
   parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rd_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
   input  logic                  ifid_uses_rs2_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ack_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  noop_o,
   output logic                  ifid_flush_o,
   output logic                  backend_hold_o,
   output logic                  mem_err_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o,
   output state_e                state_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e              state_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                load_use;
   logic                mem_stall;
   logic                lu_stall;
   logic                br_flush;

   hazard_load_use_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_load_use (
      .idex_memread (idex_memread_i),
      .idex_rd      (idex_rd_i),
      .ifid_rs1     (ifid_rs1_i),
      .ifid_rs2     (ifid_rs2_i),
      .ifid_uses_rs2(ifid_uses_rs2_i),
      .load_use     (load_use)
   );

   // Memory handshake: mem_req_i marks an access in MEM; the access completes
   // in the cycle mem_ack_i is high. Req with ack in the same cycle is zero-wait.
   always_comb begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      noop_o         = 1'b0;
      ifid_flush_o   = 1'b0;
      backend_hold_o = 1'b0;
      mem_stall      = 1'b0;
      lu_stall       = 1'b0;
      br_flush       = 1'b0;
      case (state_q)
         ST_IDLE: noop_o = 1'b1;
         ST_RUN: begin
            if (mem_req_i && !mem_ack_i) begin
               backend_hold_o = 1'b1;
               mem_stall      = 1'b1;
            end else if (load_use) begin
               // A same-cycle branch is dropped; it re-resolves after the bubble.
               noop_o   = 1'b1;
               lu_stall = 1'b1;
            end else if (branch_taken_i) begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
               ifid_flush_o = 1'b1;
               br_flush     = 1'b1;
            end else begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
            end
         end
         ST_MEM_WAIT: backend_hold_o = 1'b1;
         ST_ERR: begin
            backend_hold_o = 1'b1;
            noop_o         = 1'b1;
         end
         default: noop_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         mem_err_o   <= 1'b0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (mem_stall) begin
                  state_q <= ST_MEM_WAIT;
                  wait_q  <= WAIT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack_i) begin
                  state_q <= ST_RUN;
                  wait_q  <= '0;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
                  if (wait_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                     state_q   <= ST_ERR;
                     mem_err_o <= 1'b1;
                  end
               end
            end
            ST_ERR: mem_err_o <= 1'b1;
            default: state_q <= ST_IDLE;
         endcase

         // Statistics saturate rather than wrap.
         if ((mem_stall || lu_stall || state_q == ST_MEM_WAIT) && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (br_flush && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for the stall/flush sequencer: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_sequencer;

   localparam int RW  = 5;
   localparam int TMO = 16;
   localparam int CW  = 16;
   localparam int CW4 = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start, memread, uses2, br, req, ack;
   logic [RW-1:0] rd, rs1, rs2;

   logic pc_w, ifid_w, noop, flush, hold, err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [1:0] state;
   logic pc_w4, ifid_w4, noop4, flush4, hold4, err4;
   logic [CW4-1:0] stall_cnt4, flush_cnt4;
   logic [1:0] state4;
   logic [4:0] ctrl, ctrl4;

   int checks = 0;
   int errors = 0;

   // Model: run/wait/error flags, cycles spent waiting, statistics per width.
   int m_active, m_waiting, m_err, m_wait;
   int m_stall, m_flush, m_stall4, m_flush4;

   always #5 clk = ~clk;

   pipeline_hazard_sequencer #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .idex_memread_i(memread),
      .idex_rd_i(rd), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_uses_rs2_i(uses2),
      .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
      .pc_write_o(pc_w), .ifid_write_o(ifid_w), .noop_o(noop), .ifid_flush_o(flush),
      .backend_hold_o(hold), .mem_err_o(err), .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt), .state_o(state)
   );

   pipeline_hazard_sequencer #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW4)) dut4 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .idex_memread_i(memread),
      .idex_rd_i(rd), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_uses_rs2_i(uses2),
      .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
      .pc_write_o(pc_w4), .ifid_write_o(ifid_w4), .noop_o(noop4), .ifid_flush_o(flush4),
      .backend_hold_o(hold4), .mem_err_o(err4), .stall_cnt_o(stall_cnt4),
      .flush_cnt_o(flush_cnt4), .state_o(state4)
   );

   assign ctrl  = {pc_w, ifid_w, noop, flush, hold};
   assign ctrl4 = {pc_w4, ifid_w4, noop4, flush4, hold4};

   function automatic int sat(int v, int w);
      int mx = (1 << w) - 1;
      return (v >= mx) ? mx : v + 1;
   endfunction

   function automatic bit model_lu();
      return memread && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
   endfunction

   // Expected {pc_write, ifid_write, noop, ifid_flush, backend_hold}.
   function automatic logic [4:0] exp_ctrl();
      if (m_err) return 5'b00101;
      if (!m_active) return 5'b00100;
      if (m_waiting || (req && !ack)) return 5'b00001;
      if (model_lu()) return 5'b00100;
      if (br) return 5'b11010;
      return 5'b11000;
   endfunction

   function automatic logic [1:0] exp_state();
      if (m_err) return 2'd3;
      if (m_waiting) return 2'd2;
      if (m_active) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_active = 0; m_waiting = 0; m_err = 0; m_wait = 0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
   endtask

   // Advance one clock: predict the next model state from current inputs, then
   // cross the rising edge and return at the following falling edge.
   task automatic tick();
      int n_active  = m_active;
      int n_waiting = m_waiting;
      int n_err     = m_err;
      int n_wait    = m_wait;
      bit stall_ev  = 0;
      bit flush_ev  = 0;
      if (m_err) begin
      end else if (!m_active) begin
         if (start) n_active = 1;
      end else if (m_waiting) begin
         stall_ev = 1;
         if (ack) begin
            n_waiting = 0;
            n_wait    = 0;
         end else begin
            n_wait = m_wait + 1;
            if (n_wait >= TMO) n_err = 1;
         end
      end else if (req && !ack) begin
         stall_ev  = 1;
         n_waiting = 1;
         n_wait    = 1;
      end else if (model_lu()) begin
         stall_ev = 1;
      end else if (br) begin
         flush_ev = 1;
      end
      @(posedge clk);
      #1;
      m_active = n_active; m_waiting = n_waiting; m_err = n_err; m_wait = n_wait;
      if (stall_ev) begin
         m_stall  = sat(m_stall, CW);
         m_stall4 = sat(m_stall4, CW4);
      end
      if (flush_ev) begin
         m_flush  = sat(m_flush, CW);
         m_flush4 = sat(m_flush4, CW4);
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      start = 0; memread = 0; rd = '0; rs1 = '0; rs2 = '0;
      uses2 = 0; br = 0; req = 0; ack = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic go_run();
      do_reset();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (ctrl !== 5'b00100) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 5'b00100); end
      checks++;
      if (state !== 2'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_state: state %0d err %b expected 0 0", state, err); end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_counters: stall %0d flush %0d expected 0 0", stall_cnt, flush_cnt); end
      do_reset();
   endtask

   task automatic test_start();
      do_reset();
      tick();
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: state %0d expected 0", state); end
      start = 1;
      tick();
      start = 0;
      #1;
      checks++;
      if (state !== 2'd1) begin errors++; $display("FAIL start_run: state %0d expected 1", state); end
      checks++;
      if (ctrl !== 5'b11000) begin errors++; $display("FAIL run_ctrl: got %b expected %b", ctrl, 5'b11000); end
   endtask

   task automatic test_load_use();
      go_run();
      memread = 1; rd = 5; rs1 = 7; rs2 = 5; uses2 = 1;
      #1;
      checks++;
      if (ctrl !== 5'b00100) begin errors++; $display("FAIL lu_rs2_ctrl: got %b expected %b", ctrl, 5'b00100); end
      tick();
      checks++;
      if (stall_cnt !== CW'(1)) begin errors++; $display("FAIL lu_rs2_stall: got %0d expected 1", stall_cnt); end
      rd = 0; rs2 = 0;
      #1;
      checks++;
      if (ctrl !== 5'b11000) begin errors++; $display("FAIL lu_x0_ctrl: got %b expected %b", ctrl, 5'b11000); end
      tick();
      checks++;
      if (stall_cnt !== CW'(1)) begin errors++; $display("FAIL lu_x0_stall: got %0d expected 1", stall_cnt); end
      rd = 9; rs1 = 9; uses2 = 0; rs2 = 3;
      #1;
      checks++;
      if (ctrl !== 5'b00100) begin errors++; $display("FAIL lu_rs1_ctrl: got %b expected %b", ctrl, 5'b00100); end
      rs1 = 2; rs2 = 9;
      #1;
      checks++;
      if (ctrl !== 5'b11000) begin errors++; $display("FAIL lu_rs2_unused: got %b expected %b", ctrl, 5'b11000); end
      clear_inputs();
   endtask

   task automatic test_lu_branch();
      go_run();
      memread = 1; rd = 3; rs1 = 3; br = 1;
      #1;
      checks++;
      if (ctrl !== 5'b00100) begin errors++; $display("FAIL lubr_ctrl: got %b expected %b", ctrl, 5'b00100); end
      tick();
      checks++;
      if (flush_cnt !== '0 || stall_cnt !== CW'(1)) begin errors++; $display("FAIL lubr_counts: flush %0d stall %0d expected 0 1", flush_cnt, stall_cnt); end
      memread = 0;
      #1;
      checks++;
      if (ctrl !== 5'b11010) begin errors++; $display("FAIL branch_ctrl: got %b expected %b", ctrl, 5'b11010); end
      tick();
      checks++;
      if (flush_cnt !== CW'(1)) begin errors++; $display("FAIL branch_count: got %0d expected 1", flush_cnt); end
      clear_inputs();
   endtask

   task automatic test_mem_ack();
      go_run();
      req = 1; ack = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== 5'b00001) begin errors++; $display("FAIL mem_hold_%0d: got %b expected %b", i, ctrl, 5'b00001); end
         tick();
      end
      ack = 1;
      #1;
      checks++;
      if (ctrl !== 5'b00001 || state !== 2'd2) begin errors++; $display("FAIL mem_ack_hold: ctrl %b state %0d expected 00001 2", ctrl, state); end
      tick();
      checks++;
      if (state !== 2'd1 || stall_cnt !== CW'(4)) begin errors++; $display("FAIL mem_ack_done: state %0d stall %0d expected 1 4", state, stall_cnt); end
      #1;
      checks++;
      if (ctrl !== 5'b11000) begin errors++; $display("FAIL mem_zero_wait: got %b expected %b", ctrl, 5'b11000); end
      tick();
      checks++;
      if (state !== 2'd1 || stall_cnt !== CW'(4)) begin errors++; $display("FAIL mem_zero_wait_cnt: state %0d stall %0d expected 1 4", state, stall_cnt); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      go_run();
      req = 1;
      tick();
      tick();
      #2;
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (state !== 2'd0 || stall_cnt !== '0 || err !== 1'b0) begin errors++; $display("FAIL async_reset: state %0d stall %0d err %b expected 0 0 0", state, stall_cnt, err); end
      clear_inputs();
      @(negedge clk);
      rst_n = 1;
      start = 1;
      tick();
      start = 0;
      #1;
      checks++;
      if (state !== 2'd1 || pc_w !== 1'b1 || stall_cnt !== '0) begin errors++; $display("FAIL restart: state %0d pc_write %b stall %0d expected 1 1 0", state, pc_w, stall_cnt); end
   endtask

   task automatic test_timeout();
      go_run();
      req = 1; ack = 0;
      for (int i = 0; i < TMO - 1; i++) tick();
      checks++;
      if (err !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL timeout_early: err %b state %0d expected 0 2", err, state); end
      tick();
      checks++;
      if (err !== 1'b1 || state !== 2'd3 || stall_cnt !== CW'(TMO)) begin errors++; $display("FAIL timeout: err %b state %0d stall %0d expected 1 3 %0d", err, state, stall_cnt, TMO); end
      ack = 1; req = 0; start = 1;
      for (int i = 0; i < 4; i++) tick();
      #1;
      checks++;
      if (err !== 1'b1 || ctrl !== 5'b00101) begin errors++; $display("FAIL err_sticky: err %b ctrl %b expected 1 00101", err, ctrl); end
      do_reset();
      checks++;
      if (err !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL err_clear: err %b state %0d expected 0 0", err, state); end
   endtask

   task automatic test_saturation();
      go_run();
      memread = 1; rd = 4; rs1 = 4;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_stall4: got %0d expected 15", stall_cnt4); end
      checks++;
      if (stall_cnt !== CW'(20)) begin errors++; $display("FAIL sat_stall16: got %0d expected 20", stall_cnt); end
      memread = 0; br = 1;
      for (int i = 0; i < 18; i++) tick();
      checks++;
      if (flush_cnt4 !== 4'd15 || flush_cnt !== CW'(18)) begin errors++; $display("FAIL sat_flush: w4 %0d w16 %0d expected 15 18", flush_cnt4, flush_cnt); end
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (m_err) do_reset();
         start   = (m_active == 0) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         memread = 1'($urandom_range(0, 1));
         rd      = RW'($urandom_range(0, 3));
         rs1     = RW'($urandom_range(0, 3));
         rs2     = RW'($urandom_range(0, 3));
         uses2   = 1'($urandom_range(0, 1));
         br      = ($urandom_range(0, 3) == 0);
         req     = ($urandom_range(0, 3) == 0);
         ack     = ($urandom_range(0, 2) == 0);
         #1;
         checks++;
         if (ctrl !== exp_ctrl() || ctrl4 !== exp_ctrl()) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b/%b expected %b", i, ctrl, ctrl4, exp_ctrl()); end
         checks++;
         if (ctrl[2] && ctrl[1]) begin errors++; $display("FAIL rand_noop_flush[%0d]: got noop=1 flush=1 expected not both", i); end
         tick();
         checks++;
         if (state !== exp_state() || err !== 1'(m_err) || state4 !== exp_state() || err4 !== 1'(m_err)) begin
            errors++; $display("FAIL rand_state[%0d]: got %0d/%b expected %0d/%0d", i, state, err, exp_state(), m_err);
         end
         checks++;
         if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || stall_cnt4 !== CW4'(m_stall4) || flush_cnt4 !== CW4'(m_flush4)) begin
            errors++; $display("FAIL rand_counters[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                               i, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, m_stall, m_flush, m_stall4, m_flush4);
         end
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      clear_inputs();
      model_reset();
      @(negedge clk);
      test_reset();
      test_start();
      test_load_use();
      test_lu_branch();
      test_mem_ack();
      test_reset_mid_wait();
      test_timeout();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
